// File: rtl/half_amp_stream.sv
// Two-stage AXI-Stream sample scaler: halves each signed sample with round-half-up,
// or passes it through unchanged, and counts completed output handshakes.
module half_amp_stream #(
    parameter int DW = 14,
    parameter int CW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] s_axis_tdata_i,
    input  logic          s_axis_tvalid_i,
    output logic          s_axis_tready_o,
    output logic [DW-1:0] m_axis_tdata_o,
    output logic          m_axis_tvalid_o,
    input  logic          m_axis_tready_i,
    input  logic          bypass_i,
    input  logic          clr_i,
    output logic [CW-1:0] sample_cnt_o
);

    logic          v1;
    logic          v2;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [CW-1:0] cnt;
    logic          s1_load;
    logic          s2_load;
    logic [DW:0]   sum;
    logic [DW-1:0] scaled;

    always_comb begin
        s2_load = !v2 || m_axis_tready_i;
        s1_load = !v1 || s2_load;
        // One extra bit keeps (in + 1) exact; dropping bit 0 is the arithmetic shift.
        sum     = {s_axis_tdata_i[DW-1], s_axis_tdata_i} + (DW+1)'(1);
        scaled  = bypass_i ? s_axis_tdata_i : sum[DW:1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            d1  <= '0;
            d2  <= '0;
            cnt <= '0;
        end else begin
            if (s2_load) begin
                v2 <= v1;
                if (v1) begin
                    d2 <= d1;
                end
            end
            if (s1_load) begin
                v1 <= s_axis_tvalid_i;
                if (s_axis_tvalid_i) begin
                    d1 <= scaled;
                end
            end
            if (clr_i) begin
                cnt <= '0;
            end else if (v2 && m_axis_tready_i) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign s_axis_tready_o = !v1 || !v2 || m_axis_tready_i;
    assign m_axis_tvalid_o = v2;
    assign m_axis_tdata_o  = d2;
    assign sample_cnt_o    = cnt;

endmodule

// File: tb/tb_half_amp_stream.sv
// Self-checking bench for half_amp_stream: directed stream, backpressure, counter wrap and
// reset cases, then a long random run against a queue-based reference model.
module tb_half_amp_stream;

    localparam int DW = 14;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 s_valid = 1'b0;
    logic                 m_ready = 1'b0;
    logic                 bypass = 1'b0;
    logic                 clr = 1'b0;
    logic signed [DW-1:0] s_data = '0;

    logic          s_ready, m_valid, s_ready_s, m_valid_s;
    logic [DW-1:0] m_data, m_data_s;
    logic [31:0]   cnt;
    logic [3:0]    cnt_s;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    int qv[$];
    int qa[$];
    int cnt_model = 0;
    int accepted = 0;
    int delivered = 0;

    always #5 clk = ~clk;

    half_amp_stream #(.DW(DW), .CW(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_axis_tdata_i(s_data), .s_axis_tvalid_i(s_valid), .s_axis_tready_o(s_ready),
        .m_axis_tdata_o(m_data), .m_axis_tvalid_o(m_valid), .m_axis_tready_i(m_ready),
        .bypass_i(bypass), .clr_i(clr), .sample_cnt_o(cnt)
    );

    // Short counter build shares all stimulus so the wrap is reachable quickly.
    half_amp_stream #(.DW(DW), .CW(4)) dut_small (
        .clk_i(clk), .rst_i(rst),
        .s_axis_tdata_i(s_data), .s_axis_tvalid_i(s_valid), .s_axis_tready_o(s_ready_s),
        .m_axis_tdata_o(m_data_s), .m_axis_tvalid_o(m_valid_s), .m_axis_tready_i(m_ready),
        .bypass_i(bypass), .clr_i(clr), .sample_cnt_o(cnt_s)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference scaling: floor((x+1)/2) written with truncating division.
    function automatic int scale(input int x, input bit byp);
        int t;
        if (byp) return x;
        t = x + 1;
        if (t >= 0) return t / 2;
        return -((1 - t) / 2);
    endfunction

    // Model: queue of accepted samples; an entry is visible once it has seen one edge
    // after its acceptance edge. Evaluated at negedge to predict the coming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            bit ev;
            bit er;
            ev = (qv.size() > 0) && (qa[0] >= 1);
            er = (qv.size() < 2) || m_ready;
            chk("cnt", cnt, cnt_model);
            chk("cnt_small", cnt_s, cnt_model % 16);
            chk("m_valid", m_valid, ev);
            chk("m_valid_small", m_valid_s, ev);
            if (ev) begin
                chk("m_data", $signed(m_data), qv[0]);
                chk("m_data_small", $signed(m_data_s), qv[0]);
            end
            chk("s_ready", s_ready, er);
            chk("s_ready_small", s_ready_s, er);
            if (rst) begin
                qv.delete();
                qa.delete();
                cnt_model = 0;
            end else begin
                if (clr) cnt_model = 0;
                else if (ev && m_ready) cnt_model++;
                if (ev && m_ready) begin
                    void'(qv.pop_front());
                    void'(qa.pop_front());
                    delivered++;
                end
                for (int i = 0; i < qa.size(); i++) qa[i]++;
                if (s_valid && er) begin
                    qv.push_back(scale(int'(s_data), bypass));
                    qa.push_back(0);
                    accepted++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream4(input bit [3:0] bp, input int ex[4], input int cnt_exp);
        int vals[4] = '{8191, -8192, -3, 1};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                s_valid = 1'b1;
                s_data  = DW'(vals[i]);
                bypass  = bp[i];
            end else begin
                s_valid = 1'b0;
                bypass  = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 4) chk("stream_data", $signed(m_data), ex[i-1]);
            chk("stream_valid", m_valid, (i >= 1 && i <= 4));
        end
        chk("stream_cnt", cnt, cnt_exp);
    endtask

    initial begin
        int base_acc;
        int base_del;
        int cyc;

        repeat (2) tick();
        mon_en = 1'b1;
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_ready", s_ready, 1);
        chk("rst_cnt", cnt, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_valid", m_valid, 0);
        chk("post_rst_data", m_data, 0);
        chk("post_rst_ready", s_ready, 1);

        // Halve-only and alternating-bypass streams at full throughput.
        m_ready = 1'b1;
        stream4(4'b0000, '{4096, -4096, -1, 1}, 4);
        stream4(4'b1010, '{4096, -8192, -1, 1}, 8);

        // Backpressure: third sample must wait, first output must hold.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 100;
        bypass  = 1'b0;
        tick();
        s_data = -201;
        bypass = 1'b1;
        tick();
        chk("bp_ready_low", s_ready, 0);
        chk("bp_valid", m_valid, 1);
        chk("bp_first", $signed(m_data), 50);
        s_data = 77;
        bypass = 1'b0;
        repeat (4) begin
            tick();
            chk("bp_hold_data", $signed(m_data), 50);
            chk("bp_hold_valid", m_valid, 1);
            chk("bp_hold_ready", s_ready, 0);
        end
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("bp_second", $signed(m_data), -201);
        tick();
        chk("bp_third", $signed(m_data), 39);
        tick();
        chk("bp_drained", m_valid, 0);
        chk("bp_cnt", cnt, 11);

        // Counter wrap on the 4-bit build, then clear colliding with a handshake.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_cnt", cnt, 0);
        s_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            s_data = DW'(i * 37 - 200);
            tick();
        end
        s_valid = 1'b0;
        repeat (3) tick();
        chk("wrap_pre_small", cnt_s, 15);
        s_valid = 1'b1;
        s_data  = -5;
        tick();
        s_valid = 1'b0;
        repeat (3) tick();
        chk("wrap_small", cnt_s, 0);
        chk("wrap_big", cnt, 16);
        s_valid = 1'b1;
        s_data  = 9;
        tick();
        s_valid = 1'b0;
        tick();
        chk("clr_hs_valid", m_valid, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_hs_cnt", cnt, 0);
        chk("clr_hs_cnt_small", cnt_s, 0);

        // Reset with both stages full; reset must override a pending handshake.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 1234;
        tick();
        s_data = -777;
        tick();
        chk("full_ready", s_ready, 0);
        rst     = 1'b1;
        m_ready = 1'b1;
        tick();
        rst     = 1'b0;
        m_ready = 1'b0;
        s_valid = 1'b0;
        chk("rst_full_valid", m_valid, 0);
        chk("rst_full_cnt", cnt, 0);
        chk("rst_full_ready", s_ready, 1);
        chk("rst_full_data", m_data, 0);
        m_ready = 1'b1;
        repeat (4) tick();
        chk("no_stale_cnt", cnt, 0);

        // Random valid/ready traffic, 10000 samples.
        base_acc = accepted;
        base_del = delivered;
        cyc = 0;
        while (accepted - base_acc < 10000 && cyc < 60000) begin
            s_valid = ($urandom_range(0, 1) == 1) && (accepted - base_acc < 10000);
            m_ready = ($urandom_range(0, 1) == 1);
            bypass  = ($urandom_range(0, 1) == 1);
            s_data  = DW'($urandom);
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (5) tick();
        chk("rand_accepted", accepted - base_acc, 10000);
        chk("rand_delivered", delivered - base_del, 10000);
        chk("rand_cnt", cnt, 10000);
        chk("rand_cnt_small", cnt_s, 10000 % 16);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
